// File: rtl/spi_state_machine.sv
// Free-running SPI master (mode 0,0) for the MCP3202 ADC: start bit, config, 12-bit result.
// Latency: one frame = CS_SETUP + 34*SCK_HALF + 1 + CS_HIGH clk; o_DATA/DATA_VALID update in DONE.
// Backpressure: none; frames repeat back-to-back, DATA_VALID is a one-clk strobe that cannot be stalled.
module spi_state_machine #(
  parameter int SCK_HALF    = 88,
  parameter int INIT_CYCLES = 3000,
  parameter int CS_SETUP    = 44,
  parameter int CS_HIGH     = 88,
  parameter bit ODD_SIGN    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MISO,
  output logic        MOSI,
  output logic        SCK,
  output logic [11:0] o_DATA,
  output logic        CS,
  output logic        DATA_VALID
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [15:0] INIT_LAST  = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HALF_LAST  = 16'(SCK_HALF - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_HIGH - 1);

  // SCK cycle index 0..16; cycles 0..3 carry the command, 4 is the null bit, 5..16 are B11..B0.
  localparam logic [4:0] LAST_BIT  = 5'd16;
  localparam logic [4:0] FIRST_DAT = 5'd5;

  state_t      state;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;
  logic [11:0] shreg;

  // Command bit presented during SCK cycle idx: start, single-ended, channel select, MSB-first.
  function automatic logic cmd_bit(input logic [4:0] idx);
    logic b;
    b = 1'b0;
    case (idx)
      5'd0, 5'd1, 5'd3: b = 1'b1;
      5'd2:             b = ODD_SIGN;
      default:          b = 1'b0;
    endcase
    return b;
  endfunction

  // Frame sequencer: all pin outputs are registered so SCK/CS/MOSI never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      CS         <= 1'b1;
      SCK        <= 1'b0;
      MOSI       <= 1'b0;
      o_DATA     <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == INIT_LAST) begin
            cnt   <= '0;
            CS    <= 1'b0;
            MOSI  <= cmd_bit(5'd0);
            state <= SETUP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!SCK) begin
              // Rising edge: MISO is only looked at inside the B11..B0 window.
              SCK <= 1'b1;
              if (bit_cnt >= FIRST_DAT) begin
                shreg <= {shreg[10:0], MISO};
              end
            end else begin
              // Falling edge: start of the next low phase, the only place MOSI moves.
              SCK <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                CS         <= 1'b1;
                MOSI       <= 1'b0;
                o_DATA     <= shreg;
                DATA_VALID <= 1'b1;
                state      <= DONE;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                MOSI    <= cmd_bit(bit_cnt + 5'd1);
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          DATA_VALID <= 1'b0;
          cnt        <= '0;
          state      <= GAP;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            CS    <= 1'b0;
            MOSI  <= cmd_bit(5'd0);
            state <= SETUP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          CS    <= 1'b1;
          SCK   <= 1'b0;
          MOSI  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_state_machine.sv
// Bench for spi_state_machine: ADC pin model feeds directed result words, scoreboard checks each DATA_VALID.
// Latency: expectations queued at CS fall, popped when DATA_VALID is seen; frame period and SCK timing measured.
// Backpressure: none; the DUT free-runs and the monitor must keep up every cycle.
module tb_spi_state_machine;

  localparam int SCK_HALF    = 88;
  localparam int INIT_CYCLES = 3000;
  localparam int CS_SETUP    = 44;
  localparam int CS_HIGH     = 88;
  localparam bit ODD_SIGN    = 1'b0;
  localparam int FRAME       = CS_SETUP + 34 * SCK_HALF + 1 + CS_HIGH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miso = 1'bz;
  logic        mosi;
  logic        sck;
  logic [11:0] o_data;
  logic        cs;
  logic        dv;

  spi_state_machine #(
    .SCK_HALF(SCK_HALF), .INIT_CYCLES(INIT_CYCLES), .CS_SETUP(CS_SETUP),
    .CS_HIGH(CS_HIGH), .ODD_SIGN(ODD_SIGN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .MISO(miso), .MOSI(mosi), .SCK(sck),
    .o_DATA(o_data), .CS(cs), .DATA_VALID(dv)
  );

  initial forever #4 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int hold_err = 0;
  int rises = 0;
  logic [11:0] exp_q[$];
  logic [11:0] tbl [0:4] = '{12'hD73, 12'h003, 12'hA5C, 12'h5A6, 12'h9E1};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_cmd(input int r);
    int b;
    b = 0;
    case (r)
      1, 2, 4: b = 1;
      3:       b = int'(ODD_SIGN);
      default: b = 0;
    endcase
    return b;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ADC pin model: drives null + 12 result bits on SCK falling edges, checks command and SCK timing.
  initial begin : adc
    int f;
    logic pcs, psck;
    int rise_t1, fall_t, hi_cnt;
    bit after_rst;
    logic [12:0] word;
    f = 0; pcs = 1'b1; psck = 1'b0; rise_t1 = 0; fall_t = 0; hi_cnt = 0;
    after_rst = 1'b1; word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        miso = 1'bz; rises = 0; after_rst = 1'b1; hi_cnt = 0; pcs = 1'b1; psck = 1'b0;
      end else begin
        if (pcs && !cs) begin
          if (!after_rst) chk("cs_high_gap", int'(hi_cnt >= CS_HIGH), 1);
          after_rst = 1'b0;
          fall_t = cyc;
          rises = 0;
          word = {1'b1, tbl[f]};
          exp_q.push_back(tbl[f]);
          if (f < 4) f++;
        end
        if (cs) begin
          miso = 1'bz;
          hi_cnt++;
          rises = 0;
        end else begin
          hi_cnt = 0;
          if (sck && !psck) begin
            rises++;
            if (rises == 1) begin
              chk("cs_to_sck1", cyc - fall_t, CS_SETUP + SCK_HALF);
              rise_t1 = cyc;
            end
            if (rises == 2) chk("sck_period", cyc - rise_t1, 2 * SCK_HALF);
            if (rises <= 4) chk($sformatf("cmd_bit%0d", rises), int'(mosi), exp_cmd(rises));
            else if (rises == 5 || rises == 17) chk($sformatf("mosi_tail%0d", rises), int'(mosi), 0);
          end
          if (!sck && psck) begin
            if (rises >= 4 && rises <= 16) miso = word[12 - (rises - 4)];
            else miso = 1'bz;
          end
        end
        pcs = cs;
        psck = sck;
      end
    end
  end

  // Scoreboard monitor: pops one expectation per DATA_VALID and checks hold/period between pulses.
  initial begin : mon
    logic [11:0] last;
    logic [11:0] e;
    int prev_t;
    bit have_prev;
    last = '0; prev_t = 0; have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = '0;
        have_prev = 1'b0;
      end else if (dv === 1'b1) begin
        chk("data_no_x", int'($isunknown(o_data)), 0);
        chk("exp_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("o_data", int'(o_data), int'(e));
        end
        if (have_prev) chk("frame_period", cyc - prev_t, FRAME);
        prev_t = cyc;
        have_prev = 1'b1;
        last = o_data;
        valid_cnt++;
      end else if (o_data !== last || dv !== 1'b0) begin
        hold_err++;
      end
    end
  end

  task automatic init_wait(input string tag);
    int n;
    bit idle_ok;
    n = 0;
    idle_ok = 1'b1;
    while (cs === 1'b1 && n < INIT_CYCLES + 100) begin
      @(negedge clk);
      n++;
      if (cs === 1'b1 && (sck !== 1'b0 || dv !== 1'b0 || o_data !== 12'h000)) idle_ok = 1'b0;
    end
    chk({tag, "_len"}, n, INIT_CYCLES);
    chk({tag, "_idle"}, int'(idle_ok), 1);
  endtask

  task automatic wait_valid(input int target);
    int n;
    n = 0;
    while (valid_cnt < target && n < (target + 1) * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("valid_count%0d", target), valid_cnt, target);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", int'(cs), 1);
    chk("rst_sck", int'(sck), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_valid", int'(dv), 0);
    #2 rst_n = 1'b1;
    init_wait("init1");
    wait_valid(3);

    // Abort frame 4 part-way through the data bits.
    n = 0;
    while (rises < 8 && n < FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("mid_shift_reached", int'(rises >= 8), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs", int'(cs), 1);
    chk("midrst_sck", int'(sck), 0);
    chk("midrst_data", int'(o_data), 0);
    chk("midrst_valid", int'(dv), 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    init_wait("init2");
    wait_valid(4);

    chk("hold_errors", hold_err, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
